sr_cmd_arbiter: RTL and testbench
=================================

Name: sr_cmd_arbiter

Overview:
Shares one SR flip-flop among N requesters that each want to set or clear it. Requests are picked round-robin and serialised onto the flop's s/r inputs. Each command gets a timed pulse, a settle window and a readback check of q. The block guarantees s and r are never high together, and returns a per-requester done or error pulse.

Parameters:
N, 4, number of requesters (2..16); IDX_W = $clog2(N) derived locally
PULSE_W, 2, cycles s or r is held high per command (1..255)
SETTLE_W, 1, idle cycles between pulse end and q check (0..255; 0 skips SETTLE)

Ports:
clock  in  1  single clock, rising edge
reset  in  1  synchronous, active-low reset
req_valid  in  N  per-requester command request, held until req_ready seen
req_op  in  N  per-requester op: 1 = set, 0 = clear; stable while req_valid high
req_ready  out  N  one-hot, one-cycle accept pulse
done  out  N  one-hot, one-cycle success pulse to the accepted requester
err  out  N  one-hot, one-cycle failure pulse (q readback mismatch)
s  out  1  set drive to SR flop, registered
r  out  1  reset drive to SR flop, registered
q_fb  in  1  q output of the SR flop
busy  out  1  high in every state except IDLE
owner  out  IDX_W  index of requester currently served; holds last value in IDLE

Behaviour:
- Reset (reset==0 at an edge): state=IDLE, ptr=0, owner=0, cnt=0, op_r=0. s, r, busy, req_ready, done and err are all 0. Reset dominates every other input.
- States: IDLE -> DRIVE -> SETTLE -> CHECK -> IDLE. SETTLE is skipped when SETTLE_W==0.
- IDLE: if any req_valid bit is set, the winner w is the first set bit searching ptr, ptr+1, ... mod N. At that edge:
  - owner<=w, op_r<=req_op[w]
  - req_ready<=onehot(w)
  - s<=op_r_next, r<=~op_r_next
  - cnt<=PULSE_W-1
  - ptr<=(w+1) mod N
  - state<=DRIVE
- DRIVE: s/r hold; cnt decrements. At cnt==0, s<=0, r<=0 and state goes to SETTLE (cnt<=SETTLE_W-1) or to CHECK.
- SETTLE: cnt decrements; at cnt==0 go to CHECK.
- CHECK (1 cycle): if q_fb==op_r then done<=onehot(owner), else err<=onehot(owner). Go to IDLE.
- Pulse outputs (req_ready, done, err) are high for exactly one cycle; otherwise 0.
- Timing, with request accepted at edge t (cycle numbering from t):
  - req_ready high in cycle 1
  - s/r high in cycles 1..PULSE_W
  - CHECK in cycle PULSE_W+SETTLE_W+1
  - done/err in cycle PULSE_W+SETTLE_W+2
  - with defaults: s/r cycles 1-2, settle cycle 3, check cycle 4, done cycle 5
- Back-to-back: the done cycle is an IDLE cycle, so a new grant can be taken at its closing edge. s/r then go high in the following cycle, leaving a minimum gap of SETTLE_W+2 cycles with s=r=0 between pulses.
- Requester protocol: drop req_valid in the cycle after req_ready. A requester still valid when the arbiter returns to IDLE is treated as a new command.
- Invariants:
  - s&r is never 1
  - at most one bit of req_ready|done|err per cycle
  - done/err go only to the requester that received req_ready
- Round-robin wrap: after serving N-1, ptr=0. A lone requester is re-granted every round.
- req_valid changes during a non-IDLE state are ignored until IDLE.
- Reset mid-operation: s/r go low at the reset edge. The in-flight command is discarded with no done/err. ptr returns to 0.
- No op elision: a command is still driven when q_fb already equals req_op.

Test Plan:
- Reset: reset=0 for 3 cycles with req_valid=4'b1111 -> s=r=0, req_ready/done/err=0, busy=0, owner=0. After release, the first grant goes to requester 0.
- Single set: bench SR model q(n+1)=s?1:r?0:q, q=0; req_valid[2]=1, req_op[2]=1 -> req_ready=4'b0100 cycle 1, s=1 cycles 1-2, r=0 throughout, done=4'b0100 cycle 5, owner=2, q=1.
- Contention: req_valid=4'b1111 re-asserted each time, ops 1,0,1,0 -> grants in order 0,1,2,3. done pulses 5 cycles apart, q toggles 1,0,1,0. The next grant wraps to 0.
- Fairness: requester 1 continuously valid, requester 2 raised during requester 1's DRIVE -> the next grant goes to 2, then to 1.
- Readback error: q_fb tied 0, req 0 op=set -> s high cycles 1-2, err=4'b0001 cycle 5, done stays 0. The next request is still served normally.
- Reset mid-DRIVE: grant to req 3, reset=0 in cycle 2 -> s=0 from the following cycle, no done/err. After release, ptr=0 and requester 0 wins over 3 when both are valid.

Source files
------------

// File: rtl/sr_cmd_arbiter.sv
// Round-robin arbiter that serialises set/clear commands from N requesters onto
// one SR flip-flop. Each command is a timed pulse, a settle window and a q readback.
module sr_cmd_arbiter #(
   parameter int  N        = 4,
   parameter int  PULSE_W  = 2,
   parameter int  SETTLE_W = 1,
   localparam int IDX_W    = $clog2(N)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [N-1:0]     req_valid,
   input  logic [N-1:0]     req_op,
   output logic [N-1:0]     req_ready,
   output logic [N-1:0]     done,
   output logic [N-1:0]     err,
   output logic             s,
   output logic             r,
   input  logic             q_fb,
   output logic             busy,
   output logic [IDX_W-1:0] owner
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DRIVE  = 2'd1;
   localparam logic [1:0] ST_SETTLE = 2'd2;
   localparam logic [1:0] ST_CHECK  = 2'd3;

   localparam logic [7:0]   PULSE_LAST  = 8'(PULSE_W - 1);
   localparam logic [7:0]   SETTLE_LAST = 8'((SETTLE_W > 0) ? SETTLE_W - 1 : 0);
   localparam logic [N-1:0] ONE         = N'(1);

   logic [1:0]       state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [IDX_W-1:0] owner_q, owner_d;
   logic [7:0]       cnt_q, cnt_d;
   logic             op_q, op_d;
   logic             s_q, s_d;
   logic             r_q, r_d;
   logic [N-1:0]     ready_q, ready_d;
   logic [N-1:0]     done_q, done_d;
   logic [N-1:0]     err_q, err_d;

   logic [2*N-1:0]   rot_wide;
   logic [N-1:0]     rot;
   logic [IDX_W-1:0] win_off;
   logic [IDX_W-1:0] win;
   logic [IDX_W-1:0] win_next;

   // Rotate requests so bit 0 is the requester at ptr; the lowest set bit wins.
   assign rot_wide = {req_valid, req_valid} >> ptr_q;
   assign rot      = rot_wide[N-1:0];

   always_comb begin
      win_off = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (rot[i]) win_off = IDX_W'(i);
      end
   end

   always_comb begin
      int sum;
      sum = int'(ptr_q) + int'(win_off);
      if (sum >= N) sum = sum - N;
      win      = IDX_W'(sum);
      win_next = (win == IDX_W'(N - 1)) ? '0 : win + IDX_W'(1);
   end

   always_comb begin
      // NOTE: every next-state signal takes its hold value first, so no branch can infer a latch.
      state_d = state_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      s_d     = s_q;
      r_d     = r_q;
      ready_d = '0;
      done_d  = '0;
      err_d   = '0;
      case (state_q)
         ST_IDLE: begin
            if (|req_valid) begin
               owner_d = win;
               op_d    = req_op[win];
               ready_d = ONE << win;
               s_d     = req_op[win];
               r_d     = ~req_op[win];
               cnt_d   = PULSE_LAST;
               ptr_d   = win_next;
               state_d = ST_DRIVE;
            end
         end
         ST_DRIVE: begin
            if (cnt_q == 8'd0) begin
               s_d = 1'b0;
               r_d = 1'b0;
               if (SETTLE_W == 0) begin
                  state_d = ST_CHECK;
               end else begin
                  state_d = ST_SETTLE;
                  cnt_d   = SETTLE_LAST;
               end
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         ST_SETTLE: begin
            if (cnt_q == 8'd0) state_d = ST_CHECK;
            else               cnt_d   = cnt_q - 8'd1;
         end
         ST_CHECK: begin
            if (q_fb == op_q) done_d = ONE << owner_q;
            else              err_d  = ONE << owner_q;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      // NOTE: reset is synchronous and clears every register, outputs included, so s/r drop
      // at the reset edge and any in-flight command vanishes without done/err.
      if (!reset) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         owner_q <= '0;
         cnt_q   <= '0;
         op_q    <= 1'b0;
         s_q     <= 1'b0;
         r_q     <= 1'b0;
         ready_q <= '0;
         done_q  <= '0;
         err_q   <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         s_q     <= s_d;
         r_q     <= r_d;
         ready_q <= ready_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign req_ready = ready_q;
   assign done      = done_q;
   assign err       = err_q;
   assign s         = s_q;
   assign r         = r_q;
   assign busy      = (state_q != ST_IDLE);
   assign owner     = owner_q;

endmodule

// File: tb/tb_sr_cmd_arbiter.sv
// Bench for sr_cmd_arbiter: a cycle-timeline model of grants and pulse windows is
// compared every cycle, plus directed scenarios with literal expectations.
module tb_sr_cmd_arbiter;

   localparam int N = 4;
   localparam int P = 2;
   localparam int S = 1;
   localparam int L = P + S + 2;

   logic         clock = 1'b0;
   logic         reset = 1'b0;
   logic [N-1:0] req_valid = '0;
   logic [N-1:0] req_op = '0;
   logic [N-1:0] req_ready, done, err;
   logic         s, r, busy;
   logic [1:0]   owner;
   logic         q_plant = 1'b0;
   logic         q_stuck0 = 1'b0;
   logic         q_fb;

   int tests = 0;
   int failed = 0;

   sr_cmd_arbiter #(.N(N), .PULSE_W(P), .SETTLE_W(S)) dut (
      .clock     (clock),
      .reset     (reset),
      .req_valid (req_valid),
      .req_op    (req_op),
      .req_ready (req_ready),
      .done      (done),
      .err       (err),
      .s         (s),
      .r         (r),
      .q_fb      (q_fb),
      .busy      (busy),
      .owner     (owner)
   );

   always #5 clock = ~clock;

   // SR flop being driven; the stuck mode forces the readback low.
   always @(posedge clock) begin
      if (s === 1'b1)      q_plant <= 1'b1;
      else if (r === 1'b1) q_plant <= 1'b0;
   end
   assign q_fb = q_stuck0 ? 1'b0 : q_plant;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: actual=%0d required=%0d at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      tests++;
      failed++;
      $display("FAIL %s: timed out waiting for DUT at t=%0t", name, $time);
   endtask

   // Model: a command granted at edge t0 owns cycles t0+1 .. t0+L, where cycle
   // p = 1..P drives s/r, p = L-1 is the check, p = L carries done/err.
   int     cyc = 0;
   bit     m_valid = 0;
   bit     m_active = 0;
   int     m_t0 = 0;
   int     m_ptr = 0;
   int     m_owner = 0;
   bit     m_op = 0;
   bit     m_ok = 0;
   logic [N-1:0] e_ready, e_done, e_err;
   logic   e_s, e_r, e_busy;

   always @(posedge clock) begin
      int  p, w;
      bit  found;
      cyc++;
      if (!reset) begin
         m_active = 0;
         m_ptr    = 0;
         m_owner  = 0;
         m_op     = 0;
      end else begin
         if (m_active && (cyc - m_t0) == L - 1) m_ok = (q_fb == m_op);
         if (m_active && (cyc - m_t0) >= L) m_active = 0;
         if (!m_active && req_valid != '0) begin
            found = 0;
            w = 0;
            for (int i = 0; i < N; i++) begin
               int k;
               k = (m_ptr + i) % N;
               if (!found && ((req_valid >> k) & 1) != 0) begin
                  found = 1;
                  w = k;
               end
            end
            m_active = 1;
            m_t0     = cyc;
            m_owner  = w;
            m_op     = ((req_op >> w) & 1) != 0;
            m_ptr    = (w + 1) % N;
         end
      end
      p       = cyc - m_t0 + 1;
      e_ready = (m_active && p == 1) ? N'(1) << m_owner : '0;
      e_s     = m_active && p >= 1 && p <= P && m_op;
      e_r     = m_active && p >= 1 && p <= P && !m_op;
      e_busy  = m_active && p >= 1 && p <= L - 1;
      e_done  = (m_active && p == L && m_ok) ? N'(1) << m_owner : '0;
      e_err   = (m_active && p == L && !m_ok) ? N'(1) << m_owner : '0;
      m_valid = 1;
   end

   always @(negedge clock) begin
      if (m_valid) begin
         check("req_ready", req_ready, e_ready);
         check("done", done, e_done);
         check("err", err, e_err);
         check("s", s, e_s);
         check("r", r, e_r);
         check("busy", busy, e_busy);
         check("owner", owner, m_owner);
         check("s_and_r", s & r, 0);
      end
   end

   // Event log read by the directed scenarios.
   int g_idx[$], g_cyc[$];
   int f_idx[$], f_cyc[$], f_err[$], f_q[$];
   int s_cnt = 0, r_cnt = 0;

   always @(negedge clock) begin
      for (int i = 0; i < N; i++) begin
         if (req_ready[i] === 1'b1) begin
            g_idx.push_back(i);
            g_cyc.push_back(cyc);
         end
         if (done[i] === 1'b1 || err[i] === 1'b1) begin
            f_idx.push_back(i);
            f_cyc.push_back(cyc);
            f_err.push_back(err[i] === 1'b1 ? 1 : 0);
            f_q.push_back(q_plant === 1'b1 ? 1 : 0);
         end
      end
      if (s === 1'b1) s_cnt++;
      if (r === 1'b1) r_cnt++;
   end

   task automatic tick();
      @(negedge clock);
      #1;
   endtask

   task automatic wait_grants(input int target, input string name);
      int n = 0;
      while (g_idx.size() < target && n < 100) begin
         tick();
         n++;
      end
      if (g_idx.size() < target) timeout(name);
   endtask

   task automatic wait_fins(input int target, input string name);
      int n = 0;
      while (f_idx.size() < target && n < 100) begin
         tick();
         n++;
      end
      if (f_idx.size() < target) timeout(name);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int gb, fb, sc, rc;

      // Reset held with every requester valid.
      reset = 1'b0;
      req_valid = '1;
      req_op = '0;
      repeat (3) begin
         tick();
         check("rst_s", s, 0);
         check("rst_r", r, 0);
         check("rst_ready", req_ready, 0);
         check("rst_done", done, 0);
         check("rst_err", err, 0);
         check("rst_busy", busy, 0);
         check("rst_owner", owner, 0);
      end
      reset = 1'b1;
      wait_grants(1, "rst_grant");
      check("rst_first_grant", g_idx[0], 0);
      req_valid = '0;
      wait_fins(1, "rst_fin");

      // Single set from requester 2.
      gb = g_idx.size(); fb = f_idx.size(); sc = s_cnt; rc = r_cnt;
      req_op[2] = 1'b1;
      req_valid[2] = 1'b1;
      wait_grants(gb + 1, "set_grant");
      req_valid[2] = 1'b0;
      wait_fins(fb + 1, "set_fin");
      check("set_grant_idx", g_idx[gb], 2);
      check("set_done_idx", f_idx[fb], 2);
      check("set_is_err", f_err[fb], 0);
      check("set_latency", f_cyc[fb] - g_cyc[gb], 4);
      check("set_owner", owner, 2);
      check("set_q", q_plant, 1);
      check("set_s_cycles", s_cnt - sc, 2);
      check("set_r_cycles", r_cnt - rc, 0);

      // Contention: all four valid, ops 1,0,1,0.
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      gb = g_idx.size(); fb = f_idx.size();
      req_op = 4'b0101;
      req_valid = '1;
      wait_grants(gb + 5, "cont_grant");
      req_valid = '0;
      wait_fins(fb + 5, "cont_fin");
      for (int i = 0; i < 5; i++) begin
         check("cont_order", g_idx[gb + i], i % 4);
         check("cont_q", f_q[fb + i], (i % 2 == 0) ? 1 : 0);
         if (i > 0) check("cont_spacing", f_cyc[fb + i] - f_cyc[fb + i - 1], 5);
      end

      // Fairness: 1 held, 2 raised during 1's DRIVE.
      gb = g_idx.size(); fb = f_idx.size();
      req_op[1] = 1'b1;
      req_op[2] = 1'b0;
      req_valid[1] = 1'b1;
      wait_grants(gb + 1, "fair_grant1");
      tick();
      req_valid[2] = 1'b1;
      wait_grants(gb + 3, "fair_grant3");
      req_valid = '0;
      wait_fins(fb + 3, "fair_fin");
      check("fair_g0", g_idx[gb], 1);
      check("fair_g1", g_idx[gb + 1], 2);
      check("fair_g2", g_idx[gb + 2], 1);

      // Readback error with q stuck low, then a normal clear.
      q_stuck0 = 1'b1;
      gb = g_idx.size(); fb = f_idx.size(); sc = s_cnt;
      req_op[0] = 1'b1;
      req_valid[0] = 1'b1;
      wait_grants(gb + 1, "err_grant");
      req_valid[0] = 1'b0;
      wait_fins(fb + 1, "err_fin");
      check("err_grant_idx", g_idx[gb], 0);
      check("err_fin_idx", f_idx[fb], 0);
      check("err_is_err", f_err[fb], 1);
      check("err_latency", f_cyc[fb] - g_cyc[gb], 4);
      check("err_s_cycles", s_cnt - sc, 2);
      req_op[3] = 1'b0;
      req_valid[3] = 1'b1;
      wait_grants(gb + 2, "err_next_grant");
      req_valid[3] = 1'b0;
      wait_fins(fb + 2, "err_next_fin");
      check("err_next_idx", g_idx[gb + 1], 3);
      check("err_next_is_err", f_err[fb + 1], 0);
      q_stuck0 = 1'b0;

      // Reset in the middle of DRIVE.
      gb = g_idx.size(); fb = f_idx.size();
      req_op[3] = 1'b1;
      req_valid[3] = 1'b1;
      wait_grants(gb + 1, "mid_grant");
      req_valid[3] = 1'b0;
      check("mid_grant_idx", g_idx[gb], 3);
      check("mid_s_high", s, 1);
      tick();
      reset = 1'b0;
      tick();
      check("mid_s_low", s, 0);
      check("mid_busy_low", busy, 0);
      tick();
      tick();
      check("mid_no_fin", f_idx.size() - fb, 0);
      req_op[0] = 1'b0;
      req_op[3] = 1'b1;
      req_valid = 4'b1001;
      reset = 1'b1;
      wait_grants(gb + 2, "mid_after_grant");
      req_valid[0] = 1'b0;
      check("mid_after_idx", g_idx[gb + 1], 0);
      wait_grants(gb + 3, "mid_then_grant");
      req_valid = '0;
      check("mid_then_idx", g_idx[gb + 2], 3);
      wait_fins(fb + 2, "mid_fins");
      check("mid_fin0", f_idx[fb], 0);
      check("mid_fin1", f_idx[fb + 1], 3);
      repeat (3) tick();

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
